traffic_phase_scheduler: RTL and testbench
==========================================

# traffic_phase_scheduler

Demand-actuated phase scheduler for a two-approach intersection (approach A, approach B). It sequences the six-phase green/yellow/all-red cycle and arbitrates the shared intersection between the approaches, using vehicle detectors and latched pedestrian requests. Green can be extended, and the controller rests in green when there is no conflicting demand. It drives the same one-hot lamp encoding as the fixed-time controller and replaces it where detectors are fitted.

## Interface
- CW, 4: width of the phase counter; every timing parameter must be ≤ 2^CW−1
- GMIN, 5: minimum green, in cycles
- GMAX, 15: maximum green while own-approach traffic is present; must be ≥ GMIN
- YEL, 3: yellow duration, in cycles
- AR, 2: all-red clearance, in cycles
- WALK, 4: walk indication duration; must be ≤ GMIN
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- car_a, car_b  input  1  vehicle present on approach A / B (level)
- ped_a, ped_b  input  1  pedestrian button for crossing with A / B (one-cycle pulse or level)
- LightA, LightB  output  3  lamp, one-hot: 3'b001 green, 3'b010 yellow, 3'b100 red
- walk_a, walk_b  output  1  walk indication for approach A / B
- phase  output  3  current state code

## Operation
- States and codes:
  - A_GRN = 0: A 001, B 100
  - A_YEL = 1: A 010, B 100
  - AR_AB = 2: A 100, B 100
  - B_GRN = 3: A 100, B 001
  - B_YEL = 4: A 100, B 010
  - AR_BA = 5: A 100, B 100
- Codes 6 and 7 are illegal; the next state is A_GRN.
- Phase counter cnt:
  - Loads 1 on the first cycle of each state and increments each cycle while in that state.
  - In the green states it saturates at GMAX.
- Demand latches dem_a and dem_b:
  - dem_a sets on car_a | ped_a while the state ≠ A_GRN and is held clear while in A_GRN.
  - dem_b behaves the same way, with the roles of A and B swapped.
- Opposing demand during A_GRN: oppB = dem_b | car_b | ped_b. oppA is defined the same way for B_GRN.
- Green exit from A_GRN to A_YEL requires both:
  - cnt ≥ GMIN and oppB = 1
  - at least one of: car_a = 0, or cnt ≥ GMAX
- With no opposing demand the controller holds green indefinitely, with cnt saturated. B_GRN uses the symmetric rule.
- Yellow exits when cnt == YEL. All-red exits when cnt == AR. Sequence: A_GRN → A_YEL → AR_AB → B_GRN → B_YEL → AR_BA → A_GRN.
- Pedestrian service:
  - ped_pend_a sets on ped_a in any state.
  - On the edge entering A_GRN: walk_a turns on and walk timer wt_a loads WALK if (ped_pend_a | ped_a); ped_pend_a clears; entry clear wins over a coincident set.
  - Any ped_a pulse during A_GRN after the entry edge stays pending until the next A_GRN.
  - walk_a drops after WALK cycles, or immediately on leaving A_GRN.
  - B is symmetric.
- ped_b also counts as opposing demand for A.

## Timing
- Moore outputs:
  - LightA, LightB and phase are decoded from the registered state.
  - walk_a and walk_b are registered and aligned with the first green cycle.
- Reset (asynchronous, while reset = 0):
  - state A_GRN, cnt = 1, all latches and walk timers 0
  - LightA = 001, LightB = 100, walk_a = walk_b = 0, phase = 0
- The first cycle after reset release counts as cnt = 1 of A_GRN.
- Minimum A green with demand present = GMIN cycles. Yellow = YEL cycles. All-red = AR cycles.
- A demand input is reflected in the next-state decision in the same cycle (combinational path).
- Reset mid-sequence, including during yellow: the outputs return to the reset values asynchronously.
- Both approaches requesting with car_a held: A_GRN lasts exactly GMAX cycles.

## Test plan
- Reset then no inputs for 40 cycles → phase = 0, LightA = 001, LightB = 100 throughout; walks 0.
- car_b pulse on cycle 2 after release, car_a = 0 →
  - A_GRN for 5 cycles, A_YEL (010) for 3, AR_AB for 2, then B_GRN with LightB = 001 on cycle 11.
  - With no further demand, B_GRN then holds indefinitely.
- car_a = car_b = 1 held →
  - A_GRN lasts 15 cycles, then yellow 3, all-red 2.
  - B_GRN lasts 15 cycles, and the pattern repeats.
- ped_a pulse during B_GRN, car_b = 0 →
  - B_GRN ends at GMIN (or immediately if already past GMIN).
  - On the first A_GRN cycle walk_a = 1 for exactly 4 cycles, then 0; a second pulse during that A_GRN produces walk on the following A_GRN.
- reset asserted low for 1 cycle during A_YEL (cnt = 2) → LightA = 001 and phase = 0 asynchronously; after release, A_GRN with cnt = 1.
- ped_b asserted on the same cycle the state enters B_GRN → walk_b = 1 for 4 cycles from the first B_GRN cycle; ped_pend_b = 0 afterwards; no extra B walk on the next cycle.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated phase scheduler for a two-approach intersection.
// Sequences green/yellow/all-red for approaches A and B, extends green while
// own traffic is present (up to GMAX), rests in green without conflicting
// demand, and times a walk indication at the start of a green when a
// pedestrian has asked for it.
module traffic_phase_scheduler #(
  parameter int CW   = 4,
  parameter int GMIN = 5,
  parameter int GMAX = 15,
  parameter int YEL  = 3,
  parameter int AR   = 2,
  parameter int WALK = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_a,
  input  logic       car_b,
  input  logic       ped_a,
  input  logic       ped_b,
  output logic [2:0] LightA,
  output logic [2:0] LightB,
  output logic       walk_a,
  output logic       walk_b,
  output logic [2:0] phase
);

  localparam logic [2:0] A_GRN = 3'd0;
  localparam logic [2:0] A_YEL = 3'd1;
  localparam logic [2:0] AR_AB = 3'd2;
  localparam logic [2:0] B_GRN = 3'd3;
  localparam logic [2:0] B_YEL = 3'd4;
  localparam logic [2:0] AR_BA = 3'd5;

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] GMIN_C  = CW'(GMIN);
  localparam logic [CW-1:0] GMAX_C  = CW'(GMAX);
  localparam logic [CW-1:0] YEL_C   = CW'(YEL);
  localparam logic [CW-1:0] AR_C    = CW'(AR);
  localparam logic [CW-1:0] WALK_C  = CW'(WALK);

  logic [2:0]    state;
  logic [2:0]    nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] wt_a;
  logic [CW-1:0] wt_b;
  logic          dem_a;
  logic          dem_b;
  logic          ped_pend_a;
  logic          ped_pend_b;
  logic          opp_a;
  logic          opp_b;
  logic          exit_a;
  logic          exit_b;
  logic          enter_a;
  logic          enter_b;
  logic          in_green;

  // Opposing demand includes the live inputs so a request acts in the same cycle
  assign opp_b = dem_b | car_b | ped_b;
  assign opp_a = dem_a | car_a | ped_a;

  // Green ends only after the minimum, with someone waiting, and once own
  // traffic has cleared or the maximum has been reached
  assign exit_a = (cnt >= GMIN_C) && opp_b && (!car_a || (cnt >= GMAX_C));
  assign exit_b = (cnt >= GMIN_C) && opp_a && (!car_b || (cnt >= GMAX_C));

  assign enter_a  = (nxt == A_GRN) && (state != A_GRN);
  assign enter_b  = (nxt == B_GRN) && (state != B_GRN);
  assign in_green = (state == A_GRN) || (state == B_GRN);

  // Next-state decision for the six-phase cycle
  always_comb begin
    nxt = state;
    case (state)
      A_GRN:   if (exit_a)        nxt = A_YEL;
      A_YEL:   if (cnt == YEL_C)  nxt = AR_AB;
      AR_AB:   if (cnt == AR_C)   nxt = B_GRN;
      B_GRN:   if (exit_b)        nxt = B_YEL;
      B_YEL:   if (cnt == YEL_C)  nxt = AR_BA;
      AR_BA:   if (cnt == AR_C)   nxt = A_GRN;
      default:                    nxt = A_GRN;
    endcase
  end

  // State register and in-phase counter; counter restarts at 1 on every
  // state change and parks at GMAX while resting in green
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= A_GRN;
      cnt   <= CNT_ONE;
    end else begin
      state <= nxt;
      if (nxt != state)
        cnt <= CNT_ONE;
      else if (in_green && (cnt >= GMAX_C))
        cnt <= cnt;
      else
        cnt <= cnt + CNT_ONE;
    end
  end

  // Demand and pedestrian latches; entering a green clears that approach's
  // pending walk even if a new press arrives on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dem_a      <= 1'b0;
      dem_b      <= 1'b0;
      ped_pend_a <= 1'b0;
      ped_pend_b <= 1'b0;
    end else begin
      dem_a      <= (state == A_GRN) ? 1'b0 : (dem_a | car_a | ped_a);
      dem_b      <= (state == B_GRN) ? 1'b0 : (dem_b | car_b | ped_b);
      ped_pend_a <= enter_a ? 1'b0 : (ped_pend_a | ped_a);
      ped_pend_b <= enter_b ? 1'b0 : (ped_pend_b | ped_b);
    end
  end

  // Walk timer for A: armed on the green entry edge, counts down WALK cycles
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      walk_a <= 1'b0;
      wt_a   <= '0;
    end else if (enter_a) begin
      walk_a <= ped_pend_a | ped_a;
      wt_a   <= (ped_pend_a | ped_a) ? WALK_C : '0;
    end else if (nxt != A_GRN) begin
      walk_a <= 1'b0;
      wt_a   <= '0;
    end else if (wt_a != '0) begin
      wt_a   <= wt_a - CNT_ONE;
      walk_a <= (wt_a > CNT_ONE);
    end
  end

  // Walk timer for B, mirror of A
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      walk_b <= 1'b0;
      wt_b   <= '0;
    end else if (enter_b) begin
      walk_b <= ped_pend_b | ped_b;
      wt_b   <= (ped_pend_b | ped_b) ? WALK_C : '0;
    end else if (nxt != B_GRN) begin
      walk_b <= 1'b0;
      wt_b   <= '0;
    end else if (wt_b != '0) begin
      wt_b   <= wt_b - CNT_ONE;
      walk_b <= (wt_b > CNT_ONE);
    end
  end

  // Moore lamp decode from the registered state
  always_comb begin
    LightA = LAMP_R;
    LightB = LAMP_R;
    case (state)
      A_GRN:   LightA = LAMP_G;
      A_YEL:   LightA = LAMP_Y;
      B_GRN:   LightB = LAMP_G;
      B_YEL:   LightB = LAMP_Y;
      default: ;
    endcase
  end

  assign phase = state;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Testbench for traffic_phase_scheduler: directed scenarios plus a randomized
// run, all compared against a phase-level behavioural model.
module tb_traffic_phase_scheduler;

  localparam int CW   = 4;
  localparam int GMIN = 5;
  localparam int GMAX = 15;
  localparam int YEL  = 3;
  localparam int AR   = 2;
  localparam int WALK = 4;

  localparam logic [10:0] RESET_VEC = {3'd0, 3'b001, 3'b100, 1'b0, 1'b0};

  logic       clk = 1'b0;
  logic       reset;
  logic       car_a, car_b, ped_a, ped_b;
  logic [2:0] LightA, LightB, phase;
  logic       walk_a, walk_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_phase_scheduler #(
    .CW(CW), .GMIN(GMIN), .GMAX(GMAX), .YEL(YEL), .AR(AR), .WALK(WALK)
  ) dut (
    .clk(clk), .reset(reset),
    .car_a(car_a), .car_b(car_b), .ped_a(ped_a), .ped_b(ped_b),
    .LightA(LightA), .LightB(LightB),
    .walk_a(walk_a), .walk_b(walk_b), .phase(phase)
  );

  // Behavioural model: phase index p (0..5), approach served = p/3,
  // sub-phase = p%3 (green, yellow, all-red), time-in-phase t (unbounded).
  int m_ph;
  int m_t;
  bit m_dem  [2];
  bit m_pend [2];
  int m_wl   [2];

  task automatic model_reset();
    m_ph = 0;
    m_t  = 1;
    for (int k = 0; k < 2; k++) begin
      m_dem[k]  = 1'b0;
      m_pend[k] = 1'b0;
      m_wl[k]   = 0;
    end
  endtask

  task automatic model_step(input bit ca, input bit cb, input bit pa, input bit pb);
    bit car [2];
    bit ped [2];
    int s, sub, nph, g;
    bit adv, ent;
    car[0] = ca; car[1] = cb; ped[0] = pa; ped[1] = pb;
    s   = m_ph / 3;
    sub = m_ph % 3;
    if (sub == 0)
      adv = (m_t >= GMIN) && (m_dem[1-s] | car[1-s] | ped[1-s]) && (!car[s] || (m_t >= GMAX));
    else if (sub == 1)
      adv = (m_t == YEL);
    else
      adv = (m_t == AR);
    nph = adv ? (m_ph + 1) % 6 : m_ph;
    for (int k = 0; k < 2; k++) begin
      g   = 3 * k;
      ent = (nph == g) && (m_ph != g);
      if (ent)
        m_wl[k] = (m_pend[k] | ped[k]) ? WALK : 0;
      else if (nph != g)
        m_wl[k] = 0;
      else if (m_wl[k] > 0)
        m_wl[k] = m_wl[k] - 1;
      m_pend[k] = ent ? 1'b0 : (m_pend[k] | ped[k]);
      m_dem[k]  = (m_ph == g) ? 1'b0 : (m_dem[k] | car[k] | ped[k]);
    end
    m_t  = adv ? 1 : m_t + 1;
    m_ph = nph;
  endtask

  function automatic logic [2:0] lamp(input int k);
    if (m_ph / 3 != k) return 3'b100;
    case (m_ph % 3)
      0:       return 3'b001;
      1:       return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [10:0] model_vec();
    return {3'(m_ph), lamp(0), lamp(1), (m_wl[0] > 0), (m_wl[1] > 0)};
  endfunction

  function automatic logic [10:0] dut_vec();
    return {phase, LightA, LightB, walk_a, walk_b};
  endfunction

  // Called at a falling edge: apply inputs for one clock, advance model, move
  // to the next falling edge where outputs are sampled.
  task automatic drive(input bit ca, input bit cb, input bit pa, input bit pb);
    car_a = ca; car_b = cb; ped_a = pa; ped_b = pb;
    model_step(ca, cb, pa, pb);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    car_a = 1'b0; car_b = 1'b0; ped_a = 1'b0; ped_b = 1'b0;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic wait_phase(input logic [2:0] target, input int bound, output bit ok);
    int n = 0;
    while (phase !== target && n < bound) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      n++;
    end
    ok = (phase === target);
  endtask

  task automatic test_reset();
    car_a = 1'b0; car_b = 1'b0; ped_a = 1'b0; ped_b = 1'b0;
    reset = 1'b0;
    #2;
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_hold: got %h expected %h", dut_vec(), RESET_VEC);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    for (int c = 1; c <= 40; c++) begin
      checks++;
      if (dut_vec() !== RESET_VEC) begin
        errors++;
        $display("FAIL idle_rest c=%0d: got %h expected %h", c, dut_vec(), RESET_VEC);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_car_b_pulse();
    logic [2:0] exp_ph;
    apply_reset();
    for (int c = 1; c <= 30; c++) begin
      exp_ph = (c <= 5) ? 3'd0 : (c <= 8) ? 3'd1 : (c <= 10) ? 3'd2 : 3'd3;
      checks++;
      if (phase !== exp_ph || dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL car_b_seq c=%0d: got %h phase %0d expected %h phase %0d",
                 c, dut_vec(), phase, model_vec(), exp_ph);
      end
      if (c == 11) begin
        checks++;
        if (LightB !== 3'b001 || LightA !== 3'b100) begin
          errors++;
          $display("FAIL b_green_c11: got A=%b B=%b expected A=100 B=001", LightA, LightB);
        end
      end
      drive(1'b0, (c == 2), 1'b0, 1'b0);
    end
  endtask

  task automatic test_both_held();
    logic [2:0] exp_ph;
    int p;
    apply_reset();
    for (int c = 1; c <= 90; c++) begin
      p = (c - 1) % 40;
      exp_ph = (p < 15) ? 3'd0 : (p < 18) ? 3'd1 : (p < 20) ? 3'd2 :
               (p < 35) ? 3'd3 : (p < 38) ? 3'd4 : 3'd5;
      checks++;
      if (phase !== exp_ph || dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL both_held c=%0d: got %h phase %0d expected %h phase %0d",
                 c, dut_vec(), phase, model_vec(), exp_ph);
      end
      drive(1'b1, 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic test_ped_walk();
    bit ok;
    int bl, wc, ag, n;
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    wait_phase(3'd3, 30, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ped_reach_b: got phase %0d expected 3", phase);
    end
    bl = 0; n = 0;
    while (phase === 3'd3 && n < 30) begin
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL ped_b_green: got %h expected %h", dut_vec(), model_vec());
      end
      bl++;
      drive(1'b0, 1'b0, (bl == 1), 1'b0);
      n++;
    end
    checks++;
    if (bl != GMIN) begin
      errors++;
      $display("FAIL b_green_len: got %0d expected %0d", bl, GMIN);
    end
    for (int round = 0; round < 2; round++) begin
      wait_phase(3'd0, 30, ok);
      checks++;
      if (!ok || walk_a !== 1'b1) begin
        errors++;
        $display("FAIL walk_a_start r=%0d: got phase %0d walk %b expected phase 0 walk 1",
                 round, phase, walk_a);
      end
      wc = 0; ag = 0; n = 0;
      while (phase === 3'd0 && n < 40) begin
        checks++;
        if (dut_vec() !== model_vec()) begin
          errors++;
          $display("FAIL walk_a_green r=%0d: got %h expected %h", round, dut_vec(), model_vec());
        end
        ag++;
        wc += int'(walk_a);
        drive(1'b0, (ag == 7), (round == 0 && ag == 6), 1'b0);
        n++;
      end
      checks++;
      if (wc != WALK) begin
        errors++;
        $display("FAIL walk_a_len r=%0d: got %0d expected %0d", round, wc, WALK);
      end
      if (round == 0) begin
        wait_phase(3'd3, 30, ok);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
      end
    end
  endtask

  task automatic test_ped_b_entry();
    bit ok;
    int wc;
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    wait_phase(3'd2, 30, ok);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (!ok || phase !== 3'd3 || walk_b !== 1'b1) begin
      errors++;
      $display("FAIL walk_b_entry: got phase %0d walk_b %b expected phase 3 walk_b 1",
               phase, walk_b);
    end
    wc = 0;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL walk_b_green i=%0d: got %h expected %h", i, dut_vec(), model_vec());
      end
      wc += int'(walk_b);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (wc != WALK) begin
      errors++;
      $display("FAIL walk_b_len: got %0d expected %0d", wc, WALK);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    wait_phase(3'd0, 30, ok);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    wait_phase(3'd3, 40, ok);
    wc = 0;
    for (int i = 0; i < 8; i++) begin
      wc += int'(walk_b);
      drive(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (!ok || wc != 0) begin
      errors++;
      $display("FAIL walk_b_no_repeat: got %0d walk cycles (reached %b) expected 0", wc, ok);
    end
  endtask

  task automatic test_reset_mid_yellow();
    bit ok;
    int al, n;
    apply_reset();
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    wait_phase(3'd1, 30, ok);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (!ok || phase !== 3'd1 || LightA !== 3'b010) begin
      errors++;
      $display("FAIL yel_reach: got phase %0d A=%b expected phase 1 A=010", phase, LightA);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (dut_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", dut_vec(), RESET_VEC);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    al = 0; n = 0;
    while (phase === 3'd0 && n < 30) begin
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL post_reset: got %h expected %h", dut_vec(), model_vec());
      end
      al++;
      drive(1'b0, (al == 1), 1'b0, 1'b0);
      n++;
    end
    checks++;
    if (al != GMIN) begin
      errors++;
      $display("FAIL a_green_after_reset: got %0d expected %0d", al, GMIN);
    end
  endtask

  task automatic test_random();
    bit ca, cb, pa, pb;
    int dens;
    apply_reset();
    for (int c = 0; c < 800; c++) begin
      dens = 2 + (c / 200) * 2;
      checks++;
      if (dut_vec() !== model_vec()) begin
        errors++;
        $display("FAIL random c=%0d: got %h expected %h", c, dut_vec(), model_vec());
      end
      ca = ($urandom_range(0, dens) == 0);
      cb = ($urandom_range(0, dens) == 0);
      pa = ($urandom_range(0, 4 * dens) == 0);
      pb = ($urandom_range(0, 4 * dens) == 0);
      drive(ca, cb, pa, pb);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_car_b_pulse();
    test_both_held();
    test_ped_walk();
    test_ped_b_entry();
    test_reset_mid_yellow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
